// File: rtl/video_timing_gen_param.sv
// ---------------------------------------------------------------------------
// video_timing_gen_param
//
// Parametrised raster timing generator. It produces the H/V counters, blanking,
// sync, screen coordinates and line/frame strobes for an arcade raster. All
// state advances on the pixel clock-enable. The sync start positions can be
// nudged at runtime, and the new position takes effect at the next frame
// boundary. Screen coordinates can be mirrored for flip-screen.
//
// Every output is a register loaded from a decode of the *next* counter value.
// As a result, blanking, sync, coordinates and strobes always line up with the
// h/v counts presented in the same clock.
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_cen          pixel clock-enable; nothing changes while low
//   i_h_adj[3:0]   signed hsync shift in pixels (-8..+7), latched at frame start
//   i_v_adj[2:0]   signed vsync shift in lines  (-4..+3), latched at frame start
//   i_inv          flip screen; mirrors o_scr_x / o_scr_y
//   o_h_cnt        raw horizontal counter (0..H_TOTAL-1)
//   o_v_cnt        raw vertical counter   (0..V_TOTAL-1)
//   o_scr_x/y      visible coordinates, 0 while blanked on that axis
//   o_hblank       h_cnt >= H_ACTIVE
//   o_vblank       v_cnt >= V_ACTIVE
//   o_hsync/vsync  sync outputs, polarity set by SYNC_POL (0 = active-low)
//   o_disp         visible area (~hblank & ~vblank)
//   o_line_start   one-clock pulse with cen when h_cnt becomes 0
//   o_frame_start  one-clock pulse with cen when h_cnt and v_cnt become 0
//   o_vbl_irq      one-clock pulse with cen when v_cnt becomes V_ACTIVE at h=0
//   o_frame_cnt    8-bit frame counter, wraps
// ---------------------------------------------------------------------------
module video_timing_gen_param #(
    parameter int CNT_W    = 9,
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 288,
    parameter int HS_WIDTH = 32,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 224,
    parameter int VS_START = 240,
    parameter int VS_WIDTH = 4,
    parameter int SYNC_POL = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cen,
    input  logic [3:0]       i_h_adj,
    input  logic [2:0]       i_v_adj,
    input  logic             i_inv,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic [CNT_W-1:0] o_scr_x,
    output logic [CNT_W-1:0] o_scr_y,
    output logic             o_hblank,
    output logic             o_vblank,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_disp,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic             o_vbl_irq,
    output logic [7:0]       o_frame_cnt
);

    // Sync arithmetic uses CNT_W+1 magnitude bits plus a sign bit, so that
    // start+adjust and count-start can go negative before the modulo fold.
    localparam int SW = CNT_W + 2;

    localparam logic [CNT_W-1:0]        H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]        V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W:0]          H_ACT_E    = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]          V_ACT_E    = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W-1:0]        H_ACT_M1   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]        V_ACT_M1   = CNT_W'(V_ACTIVE - 1);
    localparam logic signed [SW-1:0]    HS_START_S = SW'(HS_START);
    localparam logic signed [SW-1:0]    HS_WIDTH_S = SW'(HS_WIDTH);
    localparam logic signed [SW-1:0]    H_TOTAL_S  = SW'(H_TOTAL);
    localparam logic signed [SW-1:0]    VS_START_S = SW'(VS_START);
    localparam logic signed [SW-1:0]    VS_WIDTH_S = SW'(VS_WIDTH);
    localparam logic signed [SW-1:0]    V_TOTAL_S  = SW'(V_TOTAL);
    localparam logic                    SYNC_ACT   = (SYNC_POL != 0);

    // Elaboration-time guard on the raster geometry.
    generate
        if (HS_WIDTH >= H_TOTAL || VS_WIDTH >= V_TOTAL ||
            H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL ||
            H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) ||
            V_ACTIVE == 0) begin : g_bad_params
            $error("video_timing_gen_param: illegal raster parameters");
        end
    endgenerate

    // The sync window is active while (cnt - (start + adj)) mod total < width.
    // Both subtractions are folded back into 0..total-1, so a window that
    // crosses the end of the line/frame wraps without a glitch.
    function automatic logic sync_hit(
        input logic [CNT_W-1:0]     cnt,
        input logic signed [SW-1:0] adj,
        input logic signed [SW-1:0] start,
        input logic signed [SW-1:0] total,
        input logic signed [SW-1:0] width
    );
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] d;
        s = start + adj;
        if (s[SW-1])
            s = s + total;
        else if (s >= total)
            s = s - total;
        d = $signed({2'b00, cnt}) - s;
        if (d[SW-1])
            d = d + total;
        return d < width;
    endfunction

    logic [CNT_W-1:0] r_h_cnt, r_v_cnt, r_scr_x, r_scr_y;
    logic             r_hblank, r_vblank, r_hsync, r_vsync, r_disp;
    logic             r_line_start, r_frame_start, r_vbl_irq;
    logic [7:0]       r_frame_cnt;
    logic [3:0]       r_h_adj_l;
    logic [2:0]       r_v_adj_l;

    logic             w_h_wrap;
    logic [CNT_W-1:0] w_h_next, w_v_next;
    logic             w_at_origin;
    logic [3:0]       w_h_adj;
    logic [2:0]       w_v_adj;
    logic             w_hblank_n, w_vblank_n;
    logic             w_hs_act, w_vs_act;
    logic [CNT_W-1:0] w_scr_x, w_scr_y;

    always_comb begin
        w_h_wrap = (r_h_cnt == H_LAST);
        w_h_next = w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
        w_v_next = r_v_cnt;
        if (w_h_wrap)
            w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);

        w_at_origin = (w_h_next == '0) && (w_v_next == '0);

        // The adjust captured at the frame boundary already governs the
        // first pixel of the new frame.
        w_h_adj = w_at_origin ? i_h_adj : r_h_adj_l;
        w_v_adj = w_at_origin ? i_v_adj : r_v_adj_l;

        w_hblank_n = ({1'b0, w_h_next} >= H_ACT_E);
        w_vblank_n = ({1'b0, w_v_next} >= V_ACT_E);

        w_hs_act = sync_hit(w_h_next, {{(SW-4){w_h_adj[3]}}, w_h_adj},
                            HS_START_S, H_TOTAL_S, HS_WIDTH_S);
        w_vs_act = sync_hit(w_v_next, {{(SW-3){w_v_adj[2]}}, w_v_adj},
                            VS_START_S, V_TOTAL_S, VS_WIDTH_S);

        w_scr_x = '0;
        if (!w_hblank_n)
            w_scr_x = i_inv ? (H_ACT_M1 - w_h_next) : w_h_next;
        w_scr_y = '0;
        if (!w_vblank_n)
            w_scr_y = i_inv ? (V_ACT_M1 - w_v_next) : w_v_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_scr_x       <= '0;
            r_scr_y       <= '0;
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b0;
            r_hsync       <= ~SYNC_ACT;
            r_vsync       <= ~SYNC_ACT;
            r_disp        <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vbl_irq     <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_h_adj_l     <= 4'd0;
            r_v_adj_l     <= 3'd0;
        end else if (i_cen) begin
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_scr_x       <= w_scr_x;
            r_scr_y       <= w_scr_y;
            r_hblank      <= w_hblank_n;
            r_vblank      <= w_vblank_n;
            r_hsync       <= w_hs_act ? SYNC_ACT : ~SYNC_ACT;
            r_vsync       <= w_vs_act ? SYNC_ACT : ~SYNC_ACT;
            r_disp        <= ~w_hblank_n & ~w_vblank_n;
            r_line_start  <= (w_h_next == '0);
            r_frame_start <= w_at_origin;
            r_vbl_irq     <= (w_h_next == '0) && ({1'b0, w_v_next} == V_ACT_E);
            if (w_at_origin) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_h_adj_l   <= i_h_adj;
                r_v_adj_l   <= i_v_adj;
            end
        end else begin
            // Strobes only ever appear on cen cycles.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_vbl_irq     <= 1'b0;
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_scr_x       = r_scr_x;
    assign o_scr_y       = r_scr_y;
    assign o_hblank      = r_hblank;
    assign o_vblank      = r_vblank;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_disp        = r_disp;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_vbl_irq     = r_vbl_irq;
    assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_gen_param.sv
// ---------------------------------------------------------------------------
// Bench for video_timing_gen_param. Three instances share the stimulus:
//   0: default 384x264 raster
//   1: small 20x10 raster, active-high sync (whole frames fit in the run)
//   2: default raster with hsync moved to 370 so it straddles the line wrap
// ---------------------------------------------------------------------------
module tb_video_timing_gen_param;

    logic       clk;
    logic       rst;
    logic       cen;
    logic [3:0] h_adj;
    logic [2:0] v_adj;
    logic       inv;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic [8:0] sx;
        logic [8:0] sy;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
        logic       disp;
        logic       ls;
        logic       fs;
        logic       irq;
        logic [7:0] fc;
    } obs_t;

    obs_t obs [3];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    logic [8:0] d0_h, d0_v, d0_sx, d0_sy;
    logic       d0_hb, d0_vb, d0_hs, d0_vs, d0_disp, d0_ls, d0_fs, d0_irq;
    logic [7:0] d0_fc;
    logic [8:0] d1_h, d1_v, d1_sx, d1_sy;
    logic       d1_hb, d1_vb, d1_hs, d1_vs, d1_disp, d1_ls, d1_fs, d1_irq;
    logic [7:0] d1_fc;
    logic [8:0] d2_h, d2_v, d2_sx, d2_sy;
    logic       d2_hb, d2_vb, d2_hs, d2_vs, d2_disp, d2_ls, d2_fs, d2_irq;
    logic [7:0] d2_fc;

    video_timing_gen_param u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_cen(cen), .i_h_adj(h_adj), .i_v_adj(v_adj), .i_inv(inv),
        .o_h_cnt(d0_h), .o_v_cnt(d0_v), .o_scr_x(d0_sx), .o_scr_y(d0_sy),
        .o_hblank(d0_hb), .o_vblank(d0_vb), .o_hsync(d0_hs), .o_vsync(d0_vs), .o_disp(d0_disp),
        .o_line_start(d0_ls), .o_frame_start(d0_fs), .o_vbl_irq(d0_irq), .o_frame_cnt(d0_fc)
    );

    video_timing_gen_param #(
        .H_TOTAL(20), .H_ACTIVE(12), .HS_START(14), .HS_WIDTH(3),
        .V_TOTAL(10), .V_ACTIVE(6), .VS_START(7), .VS_WIDTH(2), .SYNC_POL(1)
    ) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_cen(cen), .i_h_adj(h_adj), .i_v_adj(v_adj), .i_inv(inv),
        .o_h_cnt(d1_h), .o_v_cnt(d1_v), .o_scr_x(d1_sx), .o_scr_y(d1_sy),
        .o_hblank(d1_hb), .o_vblank(d1_vb), .o_hsync(d1_hs), .o_vsync(d1_vs), .o_disp(d1_disp),
        .o_line_start(d1_ls), .o_frame_start(d1_fs), .o_vbl_irq(d1_irq), .o_frame_cnt(d1_fc)
    );

    video_timing_gen_param #(
        .HS_START(370), .HS_WIDTH(32)
    ) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_cen(cen), .i_h_adj(h_adj), .i_v_adj(v_adj), .i_inv(inv),
        .o_h_cnt(d2_h), .o_v_cnt(d2_v), .o_scr_x(d2_sx), .o_scr_y(d2_sy),
        .o_hblank(d2_hb), .o_vblank(d2_vb), .o_hsync(d2_hs), .o_vsync(d2_vs), .o_disp(d2_disp),
        .o_line_start(d2_ls), .o_frame_start(d2_fs), .o_vbl_irq(d2_irq), .o_frame_cnt(d2_fc)
    );

    assign obs[0] = {d0_h, d0_v, d0_sx, d0_sy, d0_hb, d0_vb, d0_hs, d0_vs, d0_disp, d0_ls, d0_fs, d0_irq, d0_fc};
    assign obs[1] = {d1_h, d1_v, d1_sx, d1_sy, d1_hb, d1_vb, d1_hs, d1_vs, d1_disp, d1_ls, d1_fs, d1_irq, d1_fc};
    assign obs[2] = {d2_h, d2_v, d2_sx, d2_sy, d2_hb, d2_vb, d2_hs, d2_vs, d2_disp, d2_ls, d2_fs, d2_irq, d2_fc};

    // ---------------- reference model ----------------
    // Raster geometry of each instance.
    int p_ht  [3] = '{384, 20, 384};
    int p_ha  [3] = '{256, 12, 256};
    int p_hs  [3] = '{288, 14, 370};
    int p_hw  [3] = '{32,  3,  32};
    int p_vt  [3] = '{264, 10, 264};
    int p_va  [3] = '{224, 6,  224};
    int p_vs  [3] = '{240, 7,  240};
    int p_vw  [3] = '{4,   2,  4};
    int p_pol [3] = '{0,   1,  0};

    // Position is derived from the number of pixel enables since reset.
    int m_cnt  [3] = '{0, 0, 0};
    int m_hadj [3] = '{0, 0, 0};
    int m_vadj [3] = '{0, 0, 0};
    int m_inv  [3] = '{0, 0, 0};
    int m_step [3] = '{0, 0, 0};

    logic       s_rst, s_cen, s_inv;
    logic [3:0] s_hadj;
    logic [2:0] s_vadj;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic mchk(input int k, input string f, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL model i%0d %s actual=%0d expected=%0d t=%0t", k, f, act, exp, $time);
        end
    endtask

    function automatic int pmod(input int a, input int m);
        return ((a % m) + m) % m;
    endfunction

    task automatic model_check(input int k);
        int fr, pos, h, v, fc, sx, sy, hb, vb, hs, vs, disp, ls, fs, irq, inact;
        inact = (p_pol[k] != 0) ? 0 : 1;
        fr = p_ht[k] * p_vt[k];
        if (m_cnt[k] == 0) begin
            h = 0; v = 0; sx = 0; sy = 0; hb = 0; vb = 0; disp = 1;
            hs = inact; vs = inact; ls = 0; fs = 0; irq = 0; fc = 0;
        end else begin
            pos  = m_cnt[k] % fr;
            h    = pos % p_ht[k];
            v    = pos / p_ht[k];
            fc   = (m_cnt[k] / fr) % 256;
            hb   = (h >= p_ha[k]) ? 1 : 0;
            vb   = (v >= p_va[k]) ? 1 : 0;
            disp = (hb == 0 && vb == 0) ? 1 : 0;
            hs   = (pmod(h - p_hs[k] - m_hadj[k], p_ht[k]) < p_hw[k]) ? 1 - inact : inact;
            vs   = (pmod(v - p_vs[k] - m_vadj[k], p_vt[k]) < p_vw[k]) ? 1 - inact : inact;
            sx   = (hb != 0) ? 0 : ((m_inv[k] != 0) ? p_ha[k] - 1 - h : h);
            sy   = (vb != 0) ? 0 : ((m_inv[k] != 0) ? p_va[k] - 1 - v : v);
            ls   = (m_step[k] != 0 && h == 0) ? 1 : 0;
            fs   = (m_step[k] != 0 && h == 0 && v == 0) ? 1 : 0;
            irq  = (m_step[k] != 0 && h == 0 && v == p_va[k]) ? 1 : 0;
        end
        mchk(k, "h_cnt", int'(obs[k].h), h);
        mchk(k, "v_cnt", int'(obs[k].v), v);
        mchk(k, "scr_x", int'(obs[k].sx), sx);
        mchk(k, "scr_y", int'(obs[k].sy), sy);
        mchk(k, "hblank", int'(obs[k].hb), hb);
        mchk(k, "vblank", int'(obs[k].vb), vb);
        mchk(k, "hsync", int'(obs[k].hs), hs);
        mchk(k, "vsync", int'(obs[k].vs), vs);
        mchk(k, "disp", int'(obs[k].disp), disp);
        mchk(k, "line_start", int'(obs[k].ls), ls);
        mchk(k, "frame_start", int'(obs[k].fs), fs);
        mchk(k, "vbl_irq", int'(obs[k].irq), irq);
        mchk(k, "frame_cnt", int'(obs[k].fc), fc);
    endtask

    always @(posedge clk) begin
        s_rst  = rst;
        s_cen  = cen;
        s_hadj = h_adj;
        s_vadj = v_adj;
        s_inv  = inv;
        for (int k = 0; k < 3; k++) begin
            if (s_rst) begin
                m_cnt[k] = 0; m_hadj[k] = 0; m_vadj[k] = 0; m_inv[k] = 0; m_step[k] = 0;
            end else if (s_cen) begin
                m_cnt[k]  = m_cnt[k] + 1;
                m_step[k] = 1;
                m_inv[k]  = s_inv ? 1 : 0;
                if (m_cnt[k] % (p_ht[k] * p_vt[k]) == 0) begin
                    m_hadj[k] = int'($signed(s_hadj));
                    m_vadj[k] = int'($signed(s_vadj));
                end
            end else begin
                m_step[k] = 0;
            end
        end
        #2;
        for (int k = 0; k < 3; k++) model_check(k);
    end

    // ---------------- driver tasks ----------------
    task automatic step1();
        cen = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_until(input int k, input int h, input int v);
        bit hit;
        hit = 1'b0;
        cen = 1'b1;
        for (int n = 0; n < 20000 && !hit; n++) begin
            @(negedge clk);
            if (int'(obs[k].h) == h && int'(obs[k].v) == v) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach i%0d h=%0d v=%0d actual=timeout required=reached", k, h, v);
        end
    endtask

    // ---------------- directed sequence ----------------
    int ls_seen;

    initial begin
        rst = 1'b1; cen = 1'b0; h_adj = 4'd0; v_adj = 3'd0; inv = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_h0", int'(d0_h), 0);
        chk("rst_v0", int'(d0_v), 0);
        chk("rst_hb0", int'(d0_hb), 0);
        chk("rst_disp0", int'(d0_disp), 1);
        chk("rst_hs0", int'(d0_hs), 1);
        chk("rst_vs1", int'(d1_vs), 0);
        chk("rst_hs2", int'(d2_hs), 1);
        chk("rst_fc0", int'(d0_fc), 0);
        rst = 1'b0;

        // Slow pixel clock: one enable every 8 clocks for 800 enables.
        ls_seen = 0;
        for (int i = 0; i < 800; i++) begin
            cen = 1'b1;
            @(negedge clk);
            if (d0_ls) ls_seen++;
            cen = 1'b0;
            repeat (7) @(negedge clk);
        end
        chk("line_period_count", ls_seen, 2);
        chk("after800_h0", int'(d0_h), 32);
        chk("after800_v0", int'(d0_v), 2);
        chk("after800_fc1", int'(d1_fc), 4);

        // Blanking and sync edges on the default raster.
        run_until(0, 255, 2);
        chk("hb_at255", int'(d0_hb), 0);
        step1();
        chk("hb_at256", int'(d0_hb), 1);
        run_until(0, 287, 2);
        chk("hs_at287", int'(d0_hs), 1);
        step1();
        chk("hs_at288", int'(d0_hs), 0);
        run_until(0, 319, 2);
        chk("hs_at319", int'(d0_hs), 0);
        step1();
        chk("hs_at320", int'(d0_hs), 1);

        // Pixel enable held low mid-line.
        run_until(0, 100, 3);
        cen = 1'b0;
        repeat (100) @(negedge clk);
        chk("freeze_h", int'(d0_h), 100);
        chk("freeze_ls", int'(d0_ls), 0);
        step1();
        chk("resume_h", int'(d0_h), 101);

        // Hsync window straddling the line wrap.
        run_until(2, 369, 3);
        chk("wrap_hs_369", int'(d2_hs), 1);
        step1();
        chk("wrap_hs_370", int'(d2_hs), 0);
        run_until(2, 383, 3);
        chk("wrap_hs_383", int'(d2_hs), 0);
        step1();
        chk("wrap_hs_0", int'(d2_hs), 0);
        run_until(2, 17, 4);
        chk("wrap_hs_17", int'(d2_hs), 0);
        step1();
        chk("wrap_hs_18", int'(d2_hs), 1);

        // Sync adjust written mid-frame on the small raster.
        run_until(1, 0, 1);
        h_adj = 4'b1000;
        v_adj = 3'b100;
        run_until(1, 14, 1);
        chk("adj_old_hs14", int'(d1_hs), 1);
        run_until(1, 6, 2);
        chk("adj_old_hs6", int'(d1_hs), 0);
        run_until(1, 0, 0);
        chk("adj_fs", int'(d1_fs), 1);
        run_until(1, 6, 0);
        chk("adj_new_hs6", int'(d1_hs), 1);
        run_until(1, 14, 0);
        chk("adj_new_hs14", int'(d1_hs), 0);
        run_until(1, 0, 3);
        chk("adj_new_vs3", int'(d1_vs), 1);

        // Flip screen.
        inv = 1'b1;
        run_until(0, 10, 20);
        chk("inv_scr_x", int'(d0_sx), 245);
        chk("inv_scr_y", int'(d0_sy), 203);
        run_until(0, 300, 20);
        chk("inv_blank_scr_x", int'(d0_sx), 0);
        inv = 1'b0;

        // Asynchronous reset between clock edges.
        run_until(0, 200, 21);
        #1 rst = 1'b1;
        #1;
        chk("arst_h", int'(d0_h), 0);
        chk("arst_v", int'(d0_v), 0);
        chk("arst_scr_x", int'(d0_sx), 0);
        chk("arst_disp", int'(d0_disp), 1);
        chk("arst_hs", int'(d0_hs), 1);
        chk("arst_fc", int'(d0_fc), 0);
        @(negedge clk);
        rst = 1'b0;
        step1();
        chk("post_rst_h", int'(d0_h), 1);
        chk("post_rst_ls", int'(d0_ls), 0);

        // Two more small frames after reset.
        repeat (399) step1();
        chk("small_fc2", int'(d1_fc), 2);
        chk("small_fs2", int'(d1_fs), 1);
        chk("default_fc0", int'(d0_fc), 0);

        cen = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen_param.md
Name: video_timing_gen_param

Overview:
- Parametrised raster timing generator. It is the next generation of the fixed H/V counter logic inside the core's clocks/sync block.
- Produces the H/V counters, blanking, sync, screen-coordinate outputs, and line/frame strobes for any arcade raster. All of these advance on a pixel clock-enable.
- Adds two features: runtime sync-position adjust, latched at the frame boundary, and flip-screen coordinate mirroring.
- Sits between the clock-enable generator and the layer/mixer blocks, feeding HBLANK/VBLANK/HSYNC/VSYNC/SCR_X/SCR_Y.

Parameters:
- CNT_W, 9, width of the H and V counters and coordinate outputs.
- H_TOTAL, 384, pixels per line (counter 0..H_TOTAL-1).
- H_ACTIVE, 256, visible pixels; hblank when h >= H_ACTIVE.
- HS_START, 288, nominal hsync start pixel.
- HS_WIDTH, 32, hsync length in pixels.
- V_TOTAL, 264, lines per frame.
- V_ACTIVE, 224, visible lines; vblank when v >= V_ACTIVE.
- VS_START, 240, nominal vsync start line.
- VS_WIDTH, 4, vsync length in lines.
- SYNC_POL, 0, 0 = active-low sync outputs, 1 = active-high.

Ports:
- clk  in  1  system clock (53.6 MHz).
- reset  in  1  asynchronous, active-high.
- cen  in  1  pixel clock-enable; all state advances only when cen=1.
- h_adj  in  4  signed hsync shift in pixels (-8..+7).
- v_adj  in  3  signed vsync shift in lines (-4..+3).
- inv  in  1  flip screen; mirrors scr_x/scr_y.
- h_cnt  out  CNT_W  raw horizontal counter.
- v_cnt  out  CNT_W  raw vertical counter.
- scr_x  out  CNT_W  visible X coordinate; flipped when inv=1.
- scr_y  out  CNT_W  visible Y coordinate; flipped when inv=1.
- hblank  out  1  horizontal blank.
- vblank  out  1  vertical blank.
- hsync  out  1  horizontal sync, polarity per SYNC_POL.
- vsync  out  1  vertical sync, polarity per SYNC_POL.
- disp  out  1  ~hblank & ~vblank.
- line_start  out  1  one-clk pulse, coincident with cen, when h_cnt becomes 0.
- frame_start  out  1  one-clk pulse, coincident with cen, when h_cnt and v_cnt both become 0.
- vbl_irq  out  1  one-clk pulse, coincident with cen, when v_cnt becomes V_ACTIVE at h_cnt=0.
- frame_cnt  out  8  frame counter, wraps 255->0.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - h_cnt=0, v_cnt=0, scr_x=0, scr_y=0.
  - hblank=0, vblank=0, disp=1.
  - hsync/vsync inactive level.
  - All pulses 0, frame_cnt=0, latched adjusts=0.
- Counters:
  - On cen, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 when h_cnt wraps.
  - cen=0 holds every output; pulses are 0 on cycles with cen=0.
- Output registration:
  - All outputs are registered and decoded from the next counter value.
  - Every output is therefore consistent with the h_cnt/v_cnt presented in the same cycle. Latency from counter to decode is 0 as seen externally.
- Blanking: hblank = h_cnt >= H_ACTIVE; vblank = v_cnt >= V_ACTIVE.
- Sync windows:
  - hsync active while (h_cnt - (HS_START+h_adj_l)) mod H_TOTAL < HS_WIDTH.
  - vsync is the same form, using VS_START, v_adj_l, V_TOTAL, VS_WIDTH.
  - Arithmetic is CNT_W+1 bits with modulo wrap, so windows crossing the total wrap correctly. Negative adjust below 0 wraps to the end of the line/frame.
- Adjust latching:
  - h_adj/v_adj are sampled into h_adj_l/v_adj_l only on the frame_start cycle.
  - Changes mid-frame have no effect until the next frame.
- Flip screen:
  - inv=0: scr_x = h_cnt when h_cnt < H_ACTIVE, else 0. scr_y = v_cnt when v_cnt < V_ACTIVE, else 0.
  - inv=1: scr_x = H_ACTIVE-1-h_cnt and scr_y = V_ACTIVE-1-v_cnt, both forced to 0 in blank.
  - inv is applied combinationally into the next registered value; no frame latching.
- frame_cnt increments on the frame_start cycle.
- vbl_irq and frame_start never coincide (V_ACTIVE ≠ 0 is required).
- Parameter constraints:
  - HS_WIDTH < H_TOTAL, VS_WIDTH < V_TOTAL.
  - H_ACTIVE ≤ H_TOTAL, V_ACTIVE ≤ V_TOTAL.
  - H_TOTAL, V_TOTAL ≤ 2^CNT_W.
  - Violations are flagged by a synthesis-time assertion.
- Reset mid-frame: everything returns immediately to the reset values. The next cen produces h_cnt=1.

Test Plan:
- Defaults, cen every 8 clk, 2 frames:
  - Line period is 384 cen; hblank rises at h=256.
  - hsync is low for h=288..319.
  - vsync is low on lines 240..243.
  - frame_start every 101376 cen; frame_cnt 0->2.
- h_adj=-8 written at line 100:
  - Current frame keeps hsync at 288..319.
  - Next frame hsync is at 280..311.
- HS_START=370, HS_WIDTH=32 (override):
  - hsync active for h=370..383 and h=0..17.
  - Wrap is continuous with no glitch.
- inv=1 at h=10, v=20:
  - scr_x=245, scr_y=203.
  - In blank (h=300), scr_x=0.
- cen held low for 100 clk mid-line:
  - All outputs frozen; no pulses.
  - Counting resumes from the same h.
- Async reset asserted at h=200, v=150 without clk:
  - Outputs go to reset values immediately.
  - After release, the first cen gives h_cnt=1, line_start=0.
